branch_resolve_unit: RTL and testbench

Parametrised branch/jump resolution unit for the pipelined RISC-V core, sitting in EX. It succeeds the combinational branch decision logic with these additions:
- all six RV64I conditional branches, plus JAL/JALR;
- a registered redirect/flush to IF/ID;
- a direct-mapped 2-bit branch history table (BHT) that IF reads for prediction;
- saturating performance counters.

---
 rtl/branch_pkg.sv | 19 +
 rtl/bht_2bit.sv | 37 +++
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for EX-stage branch resolution: funct3 encodings,
// 2-bit BHT counter states and the sequential PC step.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/bht_2bit.sv
// Direct-mapped table of 2-bit saturating direction counters.
// Asynchronous read for IF; single write port from EX; reset to weakly-not-taken.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [BHT_DEPTH];

    // Read sees the pre-update value when IF and EX hit the same entry.
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr[i] <= WNT;
            end
        end else if (wr_en) begin
            if (wr_taken && ctr[wr_idx] != ST) begin
                ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
            end else if (!wr_taken && ctr[wr_idx] != SNT) begin
                ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: condition evaluation, target generation,
// registered redirect to IF/ID, BHT training and saturating perf counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal_funct,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic            cond_true;
    logic            f3_legal;
    logic            resolve;
    logic            br_legal;
    logic            br_illegal;
    logic            actual_taken;
    logic            mispredict;
    logic [XLEN-1:0] fall_pc;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] taken_pc;
    logic [XLEN-1:0] next_pc;
    logic [1:0]      if_ctr;
    logic            unused_bits;

    assign rs1_s = ex_rs1;
    assign rs2_s = ex_rs2;

    always_comb begin
        cond_true = 1'b0;
        f3_legal  = 1'b1;
        case (ex_funct3)
            F3_BEQ:  cond_true = (ex_rs1 == ex_rs2);
            F3_BNE:  cond_true = (ex_rs1 != ex_rs2);
            F3_BLT:  cond_true = (rs1_s < rs2_s);
            F3_BGE:  cond_true = (rs1_s >= rs2_s);
            F3_BLTU: cond_true = (ex_rs1 < ex_rs2);
            F3_BGEU: cond_true = (ex_rs1 >= ex_rs2);
            default: f3_legal  = 1'b0;
        endcase
    end

    // The EX instruction during a redirect cycle is wrong-path and ignored.
    assign resolve    = ex_valid && !redirect_valid;
    assign br_legal   = resolve && ex_branch && f3_legal;
    assign br_illegal = resolve && ex_branch && !f3_legal;

    assign fall_pc   = ex_pc + XLEN'(PC_STEP);
    assign pc_target = ex_pc + ex_imm;
    assign jalr_sum  = ex_rs1 + ex_imm;

    always_comb begin
        actual_taken = 1'b0;
        mispredict   = 1'b0;
        taken_pc     = pc_target;
        if (br_legal) begin
            actual_taken = cond_true;
            mispredict   = (cond_true != ex_pred_taken);
        end else if (resolve && ex_jal) begin
            actual_taken = 1'b1;
            mispredict   = !ex_pred_taken;
        end else if (resolve && ex_jalr) begin
            actual_taken = 1'b1;
            mispredict   = 1'b1;
            taken_pc     = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    assign next_pc = actual_taken ? taken_pc : fall_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            illegal_funct    <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_valid <= mispredict;
            illegal_funct  <= br_illegal;
            if (mispredict) begin
                redirect_pc <= next_pc;
            end
            if (br_legal && branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_ctr   (if_ctr),
        .wr_en    (br_legal),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (actual_taken)
    );

    assign if_pred_taken = if_ctr[1];

    assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], if_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model predicts each
// cycle's redirect outputs, queued at drive time and compared after the edge.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        illegal_funct;
    logic [31:0] branch_count, mispredict_count;

    typedef struct {
        logic        vld;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int          m_bht [16];
    logic [31:0] m_bc, m_mc;
    bit          m_redir;
    logic [31:0] mc_before;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN      (64),
        .BHT_DEPTH (16),
        .CNT_W     (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_jal           (ex_jal),
        .ex_jalr          (ex_jalr),
        .ex_funct3        (ex_funct3),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_pred_taken    (ex_pred_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .illegal_funct    (illegal_funct),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc    = 0;
        m_mc    = 0;
        m_redir = 0;
        q.delete();
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit v, input bit br, input bit jal, input bit jalr,
                        input logic [2:0] f3, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [63:0] pc, input logic [63:0] imm, input bit pred);
        exp_t        e;
        exp_t        got_e;
        bit          res, legal, cond, tk, mis;
        logic [63:0] tgt;
        int          idx;
        ex_valid = v; ex_branch = br; ex_jal = jal; ex_jalr = jalr;
        ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm;
        ex_pred_taken = pred; if_pc = pc;
        idx = int'(pc[5:2]);
        #1;
        check_eq("if_pred", {63'd0, if_pred_taken}, {63'd0, m_bht[idx] >= 2});

        res   = v && !m_redir;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        case (f3)
            3'b000:  cond = (rs1 == rs2);
            3'b001:  cond = (rs1 != rs2);
            3'b100:  cond = ($signed(rs1) < $signed(rs2));
            3'b101:  cond = ($signed(rs1) >= $signed(rs2));
            3'b110:  cond = (rs1 < rs2);
            3'b111:  cond = (rs1 >= rs2);
            default: cond = 0;
        endcase
        tk = 0; mis = 0; tgt = pc + imm;
        if (br) begin
            tk  = legal && cond;
            mis = legal && (tk != pred);
        end else if (jal) begin
            tk  = 1;
            mis = !pred;
        end else if (jalr) begin
            tk  = 1;
            mis = 1;
            tgt = (rs1 + imm) & ~64'd1;
        end
        if (!res) mis = 0;

        e.vld = mis;
        e.pc  = tk ? tgt : pc + 64'd4;
        e.ill = res && br && !legal;

        if (res && br && legal) begin
            if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            if (m_bc != 32'hFFFF_FFFF) m_bc++;
        end
        if (mis && m_mc != 32'hFFFF_FFFF) m_mc++;
        m_redir = mis;
        q.push_back(e);

        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check_eq("queue_empty", 64'd1, 64'd0);
        end else begin
            got_e = q.pop_front();
            check_eq("redirect_valid", {63'd0, redirect_valid}, {63'd0, got_e.vld});
            check_eq("illegal_funct", {63'd0, illegal_funct}, {63'd0, got_e.ill});
            if (got_e.vld) check_eq("redirect_pc", redirect_pc, got_e.pc);
        end
        check_eq("branch_count", {32'd0, branch_count}, {32'd0, m_bc});
        check_eq("mispredict_count", {32'd0, mispredict_count}, {32'd0, m_mc});
        @(negedge clk);
    endtask

    task automatic idle(input logic [63:0] pc);
        step(0, 0, 0, 0, 3'b000, 64'd0, 64'd0, pc, 64'd0, 0);
    endtask

    task automatic do_reset(input bit ex_busy);
        reset = 1'b1;
        ex_valid = ex_busy; ex_branch = 1; ex_jal = 0; ex_jalr = 0;
        ex_funct3 = 3'b000; ex_rs1 = 64'd3; ex_rs2 = 64'd3;
        ex_pc = 64'h0; ex_imm = 64'h40; ex_pred_taken = 0; if_pc = 64'h0;
        @(posedge clk);
        #1;
        check_eq("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        check_eq("rst_redirect_pc", redirect_pc, 64'd0);
        check_eq("rst_illegal", {63'd0, illegal_funct}, 64'd0);
        check_eq("rst_branch_count", {32'd0, branch_count}, 64'd0);
        check_eq("rst_mispredict_count", {32'd0, mispredict_count}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
        ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_pc = 0; ex_imm = 0;
        ex_pred_taken = 0; if_pc = 0;
        model_reset();
        @(negedge clk);
        do_reset(0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 64'(i * 4);
            #1;
            check_eq("rst_bht_pred", {63'd0, if_pred_taken}, 64'd0);
        end

        // BEQ taken, predicted not taken
        step(1, 1, 0, 0, 3'b000, 64'd5, 64'd5, 64'h100, 64'h20, 0);
        check_eq("t1_redirect_pc", redirect_pc, 64'h120);
        check_eq("t1_branch_count", {32'd0, branch_count}, 64'd1);
        check_eq("t1_mispredict_count", {32'd0, mispredict_count}, 64'd1);
        idle(64'h100);
        check_eq("t1_bht_pred", {63'd0, if_pred_taken}, 64'd1);

        // BLT signed taken, BLTU unsigned not taken, both correctly predicted
        step(1, 1, 0, 0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h204, 64'h10, 1);
        check_eq("t2_blt_noredir", {63'd0, redirect_valid}, 64'd0);
        step(1, 1, 0, 0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h208, 64'h10, 0);
        check_eq("t2_bltu_noredir", {63'd0, redirect_valid}, 64'd0);
        step(1, 1, 0, 0, 3'b101, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h20C, 64'h8, 0);
        step(1, 1, 0, 0, 3'b111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h210, 64'h8, 0);
        idle(64'h0);

        // BNE at 0x40 taken four times: prediction walks 0,1,1,1
        do_reset(0);
        step(1, 1, 0, 0, 3'b001, 64'd1, 64'd2, 64'h40, 64'h80, 0);
        idle(64'h40);
        check_eq("t3_pred_after1", {63'd0, if_pred_taken}, 64'd1);
        step(1, 1, 0, 0, 3'b001, 64'd1, 64'd2, 64'h40, 64'h80, 1);
        step(1, 1, 0, 0, 3'b001, 64'd1, 64'd2, 64'h40, 64'h80, 1);
        step(1, 1, 0, 0, 3'b001, 64'd1, 64'd2, 64'h40, 64'h80, 1);
        idle(64'h40);
        // A not-taken from saturated 11 must leave it predicting taken
        step(1, 1, 0, 0, 3'b001, 64'd7, 64'd7, 64'h40, 64'h80, 1);
        idle(64'h40);
        check_eq("t3_sat_pred", {63'd0, if_pred_taken}, 64'd1);

        // JALR clears bit0; JAL predicted taken is silent; JAL predicted not-taken redirects
        step(1, 0, 0, 1, 3'b000, 64'h1001, 64'd0, 64'h300, 64'h4, 1);
        check_eq("t4_jalr_pc", redirect_pc, 64'h1004);
        idle(64'h0);
        step(1, 0, 1, 0, 3'b000, 64'd0, 64'd0, 64'h310, 64'h100, 1);
        check_eq("t4_jal_noredir", {63'd0, redirect_valid}, 64'd0);
        step(1, 0, 1, 0, 3'b000, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 0);
        check_eq("t4_jal_wrap", redirect_pc, 64'h10);
        idle(64'h0);

        // Back-to-back mispredicts: the second one is squashed
        mc_before = m_mc;
        step(1, 1, 0, 0, 3'b000, 64'd9, 64'd9, 64'h400, 64'h40, 0);
        step(1, 1, 0, 0, 3'b000, 64'd9, 64'd9, 64'h404, 64'h40, 0);
        check_eq("t5_squashed", {63'd0, redirect_valid}, 64'd0);
        check_eq("t5_one_count", {32'd0, mispredict_count}, {32'd0, mc_before + 32'd1});
        step(1, 1, 0, 0, 3'b000, 64'd9, 64'd9, 64'h408, 64'h40, 0);
        check_eq("t5_resume", {63'd0, redirect_valid}, 64'd1);
        idle(64'h0);

        // Illegal funct3: pulse only, no redirect, BHT untouched
        step(1, 1, 0, 0, 3'b010, 64'd1, 64'd1, 64'h48, 64'h8, 0);
        check_eq("t6_illegal_pulse", {63'd0, illegal_funct}, 64'd1);
        step(1, 1, 0, 0, 3'b011, 64'd1, 64'd1, 64'h48, 64'h8, 1);
        idle(64'h48);
        check_eq("t6_illegal_drop", {63'd0, illegal_funct}, 64'd0);

        // Reset while a redirect is pending
        step(1, 1, 0, 0, 3'b000, 64'd2, 64'd2, 64'h40, 64'h10, 0);
        do_reset(1);
        if_pc = 64'h40;
        #1;
        check_eq("t6_bht_reset", {63'd0, if_pred_taken}, 64'd0);
        step(1, 1, 0, 0, 3'b000, 64'd2, 64'd2, 64'h40, 64'h10, 0);
        idle(64'h40);
        check_eq("t6_bht_was_wnt", {63'd0, if_pred_taken}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
